main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 The block SHALL expose parameter LATENCY, default 4, meaning cycles from accepted read to data_valid (legal 1..8).
REQ-002 The block SHALL expose parameter INIT_FILE, default "", meaning a hex image loaded into the array at elaboration when non-empty.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port enable  input  1  request strobe; one request accepted per cycle when high.
REQ-006 Port wr  input  1  request type when enable=1: 1=write, 0=read.
REQ-007 Port addr  input  16  byte address; word index = addr[15:1].
REQ-008 Port data_in  input  16  write data.
REQ-009 Port data_out  output  16  read data, registered.
REQ-010 Port data_valid  output  1  data_out holds a read response this cycle.
REQ-011 Port outstanding  output  4  count of accepted reads not yet returned.
REQ-012 Port misaligned  output  1  sticky flag: a request arrived with addr[0]=1.

Function
REQ-013 Storage SHALL be 32768 x 16-bit words, indexed by addr[15:1].
REQ-014 Read accepted at posedge N (enable=1, wr=0) SHALL sample array[addr[15:1]] at that edge and present it with data_valid=1 for exactly the cycle following posedge N+LATENCY-1 (4 edges later for default).
REQ-015 Reads SHALL be fully pipelined: back-to-back reads on consecutive cycles return on consecutive cycles, in issue order, no bubbles.
REQ-016 When no response is due, data_valid SHALL be 0 and data_out SHALL be 16'h0000.
REQ-017 Write accepted at posedge N SHALL update array[addr[15:1]] at that edge; writes produce no data_valid pulse.
REQ-018 A read accepted at posedge N+1 or later SHALL return the data written at posedge N (read-after-write visible after one edge).
REQ-019 Reads already in flight SHALL return their sampled values, unaffected by later writes to the same word.
REQ-020 outstanding SHALL increment on read accept, decrement on response retirement, hold when both occur same edge; maximum LATENCY, no overflow.
REQ-021 enable=0 SHALL insert a pipeline bubble; wr and data_in ignored.
REQ-022 misaligned SHALL set on any accepted request with addr[0]=1; the request still executes on addr[15:1]; flag clears only on reset.
REQ-023 Address wrap: addr=16'hFFFE SHALL access word 32767; no carry into other words.

Reset
REQ-024 Asserting rst SHALL immediately clear all pipeline valid bits, data_out=0, data_valid=0, outstanding=0, misaligned=0.
REQ-025 Reset mid-operation SHALL discard all in-flight reads; no response emerges after rst deasserts.
REQ-026 Array contents SHALL NOT be cleared by reset; they hold INIT_FILE image or prior writes.
REQ-027 Requests presented while rst=1 SHALL be ignored.

Structure
REQ-028 Package mem_pkg SHALL hold WORD_W=16, ADDR_W=16, MEM_WORDS=32768, and DEFAULT_LATENCY=4.
REQ-029 The latency pipeline SHALL be one sub-module mem_delay_line (LATENCY stages of {valid,data[15:0]}, async reset on valid and data).
REQ-030 data_out and data_valid SHALL come directly from mem_delay_line final stage registers; no combinational path from inputs to outputs.

Verification
REQ-031 Single read: preload word 3 = 16'hBEEF; enable=1, wr=0, addr=16'h0006 one cycle -> data_valid=1 exactly 4 cycles later with data_out=16'hBEEF, outstanding 1 then 0.
REQ-032 Burst of 8 reads addr 16'h0010..16'h001E consecutive cycles -> 8 consecutive data_valid cycles, data in address order, outstanding peaks at 4.
REQ-033 Write 16'h1234 to 16'h0040, read 16'h0040 next cycle -> returns 16'h1234 four cycles after the read.
REQ-034 Read 16'h0040 (holds 16'h1234), then write 16'hAAAA to 16'h0040 next cycle -> read returns 16'h1234.
REQ-035 Issue 3 reads, assert rst after second posedge -> data_valid stays 0 throughout and after reset, outstanding=0; array holds 16'h1234 at word 32.
REQ-036 Read addr 16'h0007 -> misaligned=1 sticky, data equals word 3; read 16'hFFFE returns word 32767.

Source files
------------

// File: rtl/main_mem_responder_pkg.sv
// Shared sizing constants and address helpers for the main memory responder.
package mem_pkg;
  localparam int WORD_W          = 16;
  localparam int ADDR_W          = 16;
  localparam int MEM_WORDS       = 32768;
  localparam int DEFAULT_LATENCY = 4;
  localparam int IDX_W           = $clog2(MEM_WORDS);
  localparam int OUTST_W         = 4;

  // Byte address to word index; bit 0 is dropped, so 16'hFFFE lands on the last word.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:1];
  endfunction
endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response bundle between a requester (master) and the memory responder (slave).
interface main_mem_responder_if;
  import mem_pkg::*;

  logic                enable;
  logic                wr;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   data_in;
  logic [WORD_W-1:0]   data_out;
  logic                data_valid;
  logic [OUTST_W-1:0]  outstanding;
  logic                misaligned;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding, misaligned
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding, misaligned
  );
endinterface

// File: rtl/main_mem_responder_delay_line.sv
// Fixed-depth {valid, data} shift pipeline; data is zeroed whenever its valid is low.
module mem_delay_line #(
  parameter int STAGES = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);
  logic              vld_p  [STAGES];
  logic [DATA_W-1:0] data_p [STAGES];

  // Stage 0: capture the sampled read word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p[0]  <= 1'b0;
      data_p[0] <= '0;
    end else begin
      vld_p[0]  <= vld_in;
      data_p[0] <= vld_in ? data_in : '0;
    end
  end

  // Stages 1..STAGES-1: plain shift
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p[g]  <= 1'b0;
        data_p[g] <= '0;
      end else begin
        vld_p[g]  <= vld_p[g-1];
        data_p[g] <= data_p[g-1];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign data_out = data_p[STAGES-1];
endmodule

// File: rtl/main_mem_responder.sv
// 32K x 16 word memory with a fixed-latency, fully pipelined read path.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int    LATENCY   = DEFAULT_LATENCY,
  parameter string INIT_FILE = ""
) (
  input logic                 clk,
  input logic                 rst,
  main_mem_responder_if.slave bus
);
  logic [WORD_W-1:0]  mem [MEM_WORDS];
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  rd_data;
  logic               rd_accept;
  logic               wr_accept;
  logic               vld_out;
  logic [WORD_W-1:0]  data_out;
  logic [OUTST_W-1:0] outstanding;
  logic               misaligned;

  assign idx       = word_index(bus.addr);
  assign rd_accept = bus.enable & ~bus.wr;
  assign wr_accept = bus.enable & bus.wr;

  // Read samples the pre-edge contents, so an in-flight read never sees a later write.
  assign rd_data = mem[idx];

  // Array has no reset; requests during reset are dropped here.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[idx] <= bus.data_in;
    end
  end

  mem_delay_line #(
    .STAGES (LATENCY),
    .DATA_W (WORD_W)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (rd_accept),
    .data_in  (rd_data),
    .vld_out  (vld_out),
    .data_out (data_out)
  );

  // A read retires on the edge after its response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      misaligned  <= 1'b0;
    end else begin
      case ({rd_accept, vld_out})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (bus.enable && bus.addr[0]) begin
        misaligned <= 1'b1;
      end
    end
  end

  assign bus.data_out    = data_out;
  assign bus.data_valid  = vld_out;
  assign bus.outstanding = outstanding;
  assign bus.misaligned  = misaligned;
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed, table-driven bench for main_mem_responder at the default latency of 4.
module tb_main_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  main_mem_responder_if bus();

  main_mem_responder #(
    .LATENCY   (4),
    .INIT_FILE ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  eo;
    logic        em;
  } vec_t;

  vec_t tbl[$];
  logic mis_now;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(input logic en, input logic wr, input logic [15:0] addr,
                              input logic [15:0] din, input logic ev, input logic [15:0] ed,
                              input logic [3:0] eo);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = addr; v.din = din;
    v.ev = ev; v.ed = ed; v.eo = eo; v.em = mis_now;
    tbl.push_back(v);
  endfunction

  // Bubble row: enable low with a write pattern that must be ignored.
  function automatic void idle(input logic ev, input logic [15:0] ed, input logic [3:0] eo);
    add(1'b0, 1'b1, 16'h0040, 16'hDEAD, ev, ed, eo);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic en, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din);
    bus.enable  = en;
    bus.wr      = wr;
    bus.addr    = addr;
    bus.data_in = din;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    mis_now = 1'b0;

    // Preload
    add(1'b1, 1'b1, 16'h0006, 16'hBEEF, 1'b0, 16'h0000, 4'd0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 1'b1, 16'(16 + 2 * i), 16'(16'hA000 + i), 1'b0, 16'h0000, 4'd0);
    add(1'b1, 1'b1, 16'hFFFE, 16'hCAFE, 1'b0, 16'h0000, 4'd0);

    // Single read
    add(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b1, 16'hBEEF, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);

    // Burst of 8 back-to-back reads
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 16'(16 + 2 * k), 16'h0000, k >= 3,
          (k >= 3) ? 16'(16'hA000 + k - 3) : 16'h0000, (k < 3) ? 4'(k + 1) : 4'd4);
    idle(1'b1, 16'hA005, 4'd3);
    idle(1'b1, 16'hA006, 4'd2);
    idle(1'b1, 16'hA007, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);

    // Read-after-write
    add(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0000, 4'd0);
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b1, 16'h1234, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);

    // Write behind an in-flight read
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd1);
    add(1'b1, 1'b1, 16'h0040, 16'hAAAA, 1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b1, 16'h1234, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);
    add(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b0, 16'h0000, 4'd1);
    idle(1'b1, 16'hAAAA, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);
    add(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 16'h0000, 4'd0);

    // Misaligned read then top-of-memory read
    mis_now = 1'b1;
    add(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 16'h0000, 4'd1);
    add(1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 4'd2);
    idle(1'b0, 16'h0000, 4'd2);
    idle(1'b1, 16'hBEEF, 4'd2);
    idle(1'b1, 16'hCAFE, 4'd1);
    idle(1'b0, 16'h0000, 4'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_valid", {15'b0, bus.data_valid}, 16'h0000);
    chk("reset data_out", bus.data_out, 16'h0000);
    chk("reset outstanding", {12'b0, bus.outstanding}, 16'h0000);
    chk("reset misaligned", {15'b0, bus.misaligned}, 16'h0000);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d data_valid", i), {15'b0, bus.data_valid}, {15'b0, tbl[i].ev});
      chk($sformatf("row%0d data_out", i), bus.data_out, tbl[i].ed);
      chk($sformatf("row%0d outstanding", i), {12'b0, bus.outstanding}, {12'b0, tbl[i].eo});
      chk($sformatf("row%0d misaligned", i), {15'b0, bus.misaligned}, {15'b0, tbl[i].em});
    end

    // Reset in the middle of three reads; third read and a write land while rst is high
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre-reset outstanding", {12'b0, bus.outstanding}, 16'h0002);
    rst = 1'b1;
    #1;
    chk("async reset data_valid", {15'b0, bus.data_valid}, 16'h0000);
    chk("async reset outstanding", {12'b0, bus.outstanding}, 16'h0000);
    chk("async reset misaligned", {15'b0, bus.misaligned}, 16'h0000);
    drive(1'b1, 1'b1, 16'h0040, 16'h5555);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'h0040, 16'hDEAD);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset cycle%0d data_valid", c), {15'b0, bus.data_valid}, 16'h0000);
      chk($sformatf("post-reset cycle%0d outstanding", c), {12'b0, bus.outstanding}, 16'h0000);
    end

    // Array survives reset and ignored requests
    drive(1'b1, 1'b0, 16'h0040, 16'h0000);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset read data_valid", {15'b0, bus.data_valid}, 16'h0001);
    chk("post-reset read data_out", bus.data_out, 16'h1234);
    chk("post-reset misaligned", {15'b0, bus.misaligned}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
